reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer for the out-of-order RISC-V core: it allocates a rename tag per dispatched instruction, collects results from the common data bus (CDB), and retires one instruction per cycle in program order. Retirement drives the register file's commit port, or the store-commit port for stores. A branch whose resolved direction differs from its prediction triggers a global rollback. It sits between the dispatcher/CDB and the register file.

## Interface
- ROB_SIZE, 16, entry count; tag = slot index + 1, tag 0 means "no producer"; legal range 2..31
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global enable; low freezes all state
- en_from_dispatcher  in  1  allocate one entry this cycle
- rd_from_dispatcher  in  5  destination register (0 = none)
- is_store_from_dispatcher  in  1  entry is a store
- is_branch_from_dispatcher  in  1  entry is a conditional branch
- pred_taken_from_dispatcher  in  1  predicted direction
- alt_pc_from_dispatcher  in  32  restart PC if the prediction is wrong
- full_to_dispatcher  out  1  no free entry (combinational)
- tag_to_dispatcher  out  5  tag that the next allocation receives
- Q1_query_from_dispatcher, Q2_query_from_dispatcher  in  5  tags to probe
- ready1_to_dispatcher, ready2_to_dispatcher  out  1  probed value is available
- V1_to_dispatcher, V2_to_dispatcher  out  32  probed value
- cdb_valid_in  in  1; cdb_tag_in  in  5; cdb_value_in  in  32; cdb_taken_in  in  1  (actual branch direction)
- commit_flag_to_regfile  out  1; rd_to_regfile  out  5; Q_to_regfile  out  5; V_to_regfile  out  32
- store_commit_flag_to_lsb  out  1; store_tag_to_lsb  out  5
- rollback_flag  out  1; rollback_pc  out  32

## Operation
- Entry fields: busy, ready, rd, is_store, is_branch, pred_taken, actual_taken, alt_pc, value.
- State: head, tail (log2 ROB_SIZE bits, wrap modulo ROB_SIZE), count (0..ROB_SIZE).
- Allocate: if en && !full, write the entry at tail with busy=1 and ready=0, then tail+1 and count+1. An allocate while full is ignored.
- Writeback: if cdb_valid and entry[cdb_tag-1] is busy, set ready=1, value, actual_taken. A CDB tag of 0 or a non-busy tag is ignored.
- Commit: if entry[head] is busy and ready:
  - Clear busy, then head+1 and count-1.
  - Store: pulse store_commit_flag_to_lsb with store_tag_to_lsb = head+1.
  - Otherwise, if rd != 0: pulse commit_flag_to_regfile with rd, Q = head+1, V = value.
  - Branch with actual_taken != pred_taken: also pulse rollback_flag with rollback_pc = alt_pc. On the same edge, clear every busy bit and set head = tail = count = 0.
- Rollback beats allocate and writeback on the same edge; those are dropped.
- Commit and allocate on the same edge: count is unchanged.
- full is computed from the pre-edge count, so a commit does not free a slot for the same cycle's allocate.
- Query, combinational, per port:
  - Q == 0: ready = 1, V = 0.
  - Else, if cdb_valid && cdb_tag == Q: ready = 1, V = cdb_value (bypass).
  - Else: ready = entry[Q-1].ready, V = entry[Q-1].value.
- rdy_in low: no state changes; the flag outputs drop to 0 at the next edge.

## Timing
- Reset (rst_in = 0 at an edge):
  - head, tail, count = 0; all busy = 0.
  - All registered outputs = 0.
  - tag_to_dispatcher = 1, full_to_dispatcher = 0.
- Reset mid-stream discards all entries; no commit or rollback is emitted.
- Commit, store-commit and rollback outputs are registered one-cycle pulses, asserted the cycle after the deciding edge.
- Latency:
  - CDB write sampled at edge k makes the entry ready after edge k.
  - The commit decision is made at edge k+1; the pulse is visible during cycle k+1..k+2.
  - Minimum dispatch-to-commit is 3 edges, including writeback at the edge after dispatch.
- Throughput: one allocate and one commit per cycle.
- rollback_flag and commit_flag_to_regfile may be high together. The register file treats rollback as clearing Q and still writes V.

## Structure
- Shared package rob_pkg:
  - ROB_SIZE and TAG_W = 5.
  - Entry struct typedef.
  - Constant NO_TAG = 0.
- No sub-module. The entry array, pointers and two query muxes stay in one module, about 250 lines.

## Test plan
- Reset, then allocate rd=5 (tag 1); CDB tag 1 value 0x1234 -> commit_flag=1, rd=5, Q=1, V=0x1234 two cycles after the CDB write.
- Allocate 16 entries -> full=1 and a 17th allocate is ignored. Complete tag 1 -> after commit, full=0 and tag_to_dispatcher wraps to 1.
- Complete tags 2, 3 before tag 1 -> no commit until tag 1 is ready, then commits of 1, 2, 3 on consecutive cycles.
- Branch (tag 1) with pred_taken=0, alt_pc=0x100; rd=7 at tag 2 completed; branch completes with taken=1 -> rollback_flag=1, rollback_pc=0x100; tag 2 is never committed; count=0.
- Query Q1=3 while cdb_tag=3, value=0xAA -> ready1=1, V1=0xAA in the same cycle. Query Q2=0 -> ready2=1.
- Store at tag 1 completes -> store_commit_flag=1, store_tag=1, commit_flag_to_regfile=0. Hold rdy_in=0 -> no pulse until rdy_in returns high.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer: sizes, entry layout
// and pointer/tag helpers.
package rob_pkg;

    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int PTR_W    = $clog2(ROB_SIZE);
    localparam int CNT_W    = $clog2(ROB_SIZE + 1);

    localparam logic [TAG_W-1:0] NO_TAG = '0;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [4:0]        rd;
        logic              is_store;
        logic              is_branch;
        logic              pred_taken;
        logic              actual_taken;
        logic [31:0]       alt_pc;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    // Pointers wrap modulo ROB_SIZE, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [TAG_W-1:0] ptr_to_tag(input logic [PTR_W-1:0] p);
        return TAG_W'(p) + TAG_W'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags, collects CDB results and
// retires in program order, flushing everything on a mispredicted branch.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,

    input  logic              en_from_dispatcher,
    input  logic [4:0]        rd_from_dispatcher,
    input  logic              is_store_from_dispatcher,
    input  logic              is_branch_from_dispatcher,
    input  logic              pred_taken_from_dispatcher,
    input  logic [31:0]       alt_pc_from_dispatcher,
    output logic              full_to_dispatcher,
    output logic [TAG_W-1:0]  tag_to_dispatcher,

    input  logic [TAG_W-1:0]  Q1_query_from_dispatcher,
    input  logic [TAG_W-1:0]  Q2_query_from_dispatcher,
    output logic              ready1_to_dispatcher,
    output logic              ready2_to_dispatcher,
    output logic [DATA_W-1:0] V1_to_dispatcher,
    output logic [DATA_W-1:0] V2_to_dispatcher,

    input  logic              cdb_valid_in,
    input  logic [TAG_W-1:0]  cdb_tag_in,
    input  logic [DATA_W-1:0] cdb_value_in,
    input  logic              cdb_taken_in,

    output logic              commit_flag_to_regfile,
    output logic [4:0]        rd_to_regfile,
    output logic [TAG_W-1:0]  Q_to_regfile,
    output logic [DATA_W-1:0] V_to_regfile,

    output logic              store_commit_flag_to_lsb,
    output logic [TAG_W-1:0]  store_tag_to_lsb,

    output logic              rollback_flag,
    output logic [31:0]       rollback_pc
);

    rob_entry_t       entries [ROB_SIZE];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    rob_entry_t       head_entry;
    logic             full;
    logic             do_alloc;
    logic             do_commit;
    logic             mispredict;
    logic [PTR_W-1:0] wb_idx;
    logic             wb_in_range;
    logic             do_wb;

    assign full        = (count == CNT_W'(ROB_SIZE));
    assign head_entry  = entries[head];
    assign do_alloc    = en_from_dispatcher && !full;
    assign do_commit   = head_entry.busy && head_entry.ready;
    assign mispredict  = head_entry.is_branch &&
                         (head_entry.actual_taken != head_entry.pred_taken);

    assign wb_idx      = PTR_W'(cdb_tag_in - TAG_W'(1));
    assign wb_in_range = (cdb_tag_in != NO_TAG) && (cdb_tag_in <= TAG_W'(ROB_SIZE));
    assign do_wb       = cdb_valid_in && wb_in_range && entries[wb_idx].busy;

    assign full_to_dispatcher = full;
    assign tag_to_dispatcher  = ptr_to_tag(tail);

    // Operand probes: tag 0 is always ready, a same-cycle CDB broadcast
    // bypasses the array, otherwise the stored entry answers.
    logic [1:0][TAG_W-1:0] q_tag;
    assign q_tag = {Q2_query_from_dispatcher, Q1_query_from_dispatcher};

    for (genvar gi = 0; gi < 2; gi++) begin : g_query
        logic              q_ready;
        logic [DATA_W-1:0] q_value;
        logic [PTR_W-1:0]  q_idx;

        assign q_idx = PTR_W'(q_tag[gi] - TAG_W'(1));

        always_comb begin
            q_ready = 1'b0;
            q_value = '0;
            if (q_tag[gi] == NO_TAG) begin
                q_ready = 1'b1;
            end else if (cdb_valid_in && cdb_tag_in == q_tag[gi]) begin
                q_ready = 1'b1;
                q_value = cdb_value_in;
            end else if (q_tag[gi] <= TAG_W'(ROB_SIZE)) begin
                q_ready = entries[q_idx].ready;
                q_value = entries[q_idx].value;
            end
        end
    end

    assign ready1_to_dispatcher = g_query[0].q_ready;
    assign V1_to_dispatcher     = g_query[0].q_value;
    assign ready2_to_dispatcher = g_query[1].q_ready;
    assign V2_to_dispatcher     = g_query[1].q_value;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head                     <= '0;
            tail                     <= '0;
            count                    <= '0;
            commit_flag_to_regfile   <= 1'b0;
            rd_to_regfile            <= '0;
            Q_to_regfile             <= '0;
            V_to_regfile             <= '0;
            store_commit_flag_to_lsb <= 1'b0;
            store_tag_to_lsb         <= '0;
            rollback_flag            <= 1'b0;
            rollback_pc              <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].busy <= 1'b0;
            end
        end else if (!rdy_in) begin
            commit_flag_to_regfile   <= 1'b0;
            store_commit_flag_to_lsb <= 1'b0;
            rollback_flag            <= 1'b0;
        end else begin
            commit_flag_to_regfile   <= 1'b0;
            store_commit_flag_to_lsb <= 1'b0;
            rollback_flag            <= 1'b0;

            if (do_commit) begin
                if (head_entry.is_store) begin
                    store_commit_flag_to_lsb <= 1'b1;
                    store_tag_to_lsb         <= ptr_to_tag(head);
                end else if (head_entry.rd != 5'd0) begin
                    commit_flag_to_regfile <= 1'b1;
                    rd_to_regfile          <= head_entry.rd;
                    Q_to_regfile           <= ptr_to_tag(head);
                    V_to_regfile           <= head_entry.value;
                end
            end

            if (do_commit && mispredict) begin
                // Flush wins over this edge's allocate and writeback.
                rollback_flag <= 1'b1;
                rollback_pc   <= head_entry.alt_pc;
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries[i].busy <= 1'b0;
                end
            end else begin
                if (do_commit) begin
                    entries[head].busy <= 1'b0;
                    head               <= ptr_inc(head);
                end
                if (do_wb) begin
                    entries[wb_idx].ready        <= 1'b1;
                    entries[wb_idx].value        <= cdb_value_in;
                    entries[wb_idx].actual_taken <= cdb_taken_in;
                end
                if (do_alloc) begin
                    entries[tail].busy       <= 1'b1;
                    entries[tail].ready      <= 1'b0;
                    entries[tail].rd         <= rd_from_dispatcher;
                    entries[tail].is_store   <= is_store_from_dispatcher;
                    entries[tail].is_branch  <= is_branch_from_dispatcher;
                    entries[tail].pred_taken <= pred_taken_from_dispatcher;
                    entries[tail].alt_pc     <= alt_pc_from_dispatcher;
                    tail                     <= ptr_inc(tail);
                end
                case ({do_alloc, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized checks of reorder_buffer against a queue-based
// program-order model of the buffer.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic        clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in, rdy_in;
    logic        en_from_dispatcher;
    logic [4:0]  rd_from_dispatcher;
    logic        is_store_from_dispatcher, is_branch_from_dispatcher, pred_taken_from_dispatcher;
    logic [31:0] alt_pc_from_dispatcher;
    logic        full_to_dispatcher;
    logic [4:0]  tag_to_dispatcher;
    logic [4:0]  Q1_query_from_dispatcher, Q2_query_from_dispatcher;
    logic        ready1_to_dispatcher, ready2_to_dispatcher;
    logic [31:0] V1_to_dispatcher, V2_to_dispatcher;
    logic        cdb_valid_in;
    logic [4:0]  cdb_tag_in;
    logic [31:0] cdb_value_in;
    logic        cdb_taken_in;
    logic        commit_flag_to_regfile;
    logic [4:0]  rd_to_regfile, Q_to_regfile;
    logic [31:0] V_to_regfile;
    logic        store_commit_flag_to_lsb;
    logic [4:0]  store_tag_to_lsb;
    logic        rollback_flag;
    logic [31:0] rollback_pc;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .en_from_dispatcher(en_from_dispatcher), .rd_from_dispatcher(rd_from_dispatcher),
        .is_store_from_dispatcher(is_store_from_dispatcher),
        .is_branch_from_dispatcher(is_branch_from_dispatcher),
        .pred_taken_from_dispatcher(pred_taken_from_dispatcher),
        .alt_pc_from_dispatcher(alt_pc_from_dispatcher),
        .full_to_dispatcher(full_to_dispatcher), .tag_to_dispatcher(tag_to_dispatcher),
        .Q1_query_from_dispatcher(Q1_query_from_dispatcher),
        .Q2_query_from_dispatcher(Q2_query_from_dispatcher),
        .ready1_to_dispatcher(ready1_to_dispatcher), .ready2_to_dispatcher(ready2_to_dispatcher),
        .V1_to_dispatcher(V1_to_dispatcher), .V2_to_dispatcher(V2_to_dispatcher),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
        .cdb_value_in(cdb_value_in), .cdb_taken_in(cdb_taken_in),
        .commit_flag_to_regfile(commit_flag_to_regfile), .rd_to_regfile(rd_to_regfile),
        .Q_to_regfile(Q_to_regfile), .V_to_regfile(V_to_regfile),
        .store_commit_flag_to_lsb(store_commit_flag_to_lsb), .store_tag_to_lsb(store_tag_to_lsb),
        .rollback_flag(rollback_flag), .rollback_pc(rollback_pc)
    );

    // Model: in-flight instructions in program order, oldest first.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          is_store, is_branch, pred, taken, ready;
        logic [31:0] alt_pc, value;
    } m_entry_t;

    m_entry_t    m_q[$];
    int          m_next_tag;
    logic        e_commit, e_store, e_rb;
    logic [4:0]  e_rd, e_q, e_stag;
    logic [31:0] e_v, e_rbpc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_edge();
        bit full;
        m_entry_t e;
        if (!rst_in) begin
            m_q.delete();
            m_next_tag = 1;
            e_commit = 0; e_store = 0; e_rb = 0;
            e_rd = 0; e_q = 0; e_stag = 0; e_v = 0; e_rbpc = 0;
            return;
        end
        e_commit = 0; e_store = 0; e_rb = 0;
        if (!rdy_in) return;
        full = (m_q.size() >= ROB_SIZE);
        if (m_q.size() > 0 && m_q[0].ready) begin
            e = m_q.pop_front();
            if (e.is_store) begin
                e_store = 1; e_stag = 5'(e.tag);
            end else if (e.rd != 0) begin
                e_commit = 1; e_rd = e.rd; e_q = 5'(e.tag); e_v = e.value;
            end
            if (e.is_branch && e.taken != e.pred) begin
                e_rb = 1; e_rbpc = e.alt_pc;
                m_q.delete();
                m_next_tag = 1;
                return;
            end
        end
        if (cdb_valid_in) begin
            foreach (m_q[i]) begin
                if (m_q[i].tag == int'(cdb_tag_in)) begin
                    m_q[i].ready = 1; m_q[i].value = cdb_value_in; m_q[i].taken = cdb_taken_in;
                end
            end
        end
        if (en_from_dispatcher && !full) begin
            e.tag = m_next_tag; e.rd = rd_from_dispatcher;
            e.is_store = is_store_from_dispatcher; e.is_branch = is_branch_from_dispatcher;
            e.pred = pred_taken_from_dispatcher; e.taken = 0; e.ready = 0;
            e.alt_pc = alt_pc_from_dispatcher; e.value = 0;
            m_q.push_back(e);
            m_next_tag = (m_next_tag == ROB_SIZE) ? 1 : m_next_tag + 1;
        end
    endtask

    task automatic m_query(input logic [4:0] q, output logic r, output logic [31:0] v);
        r = 0; v = 0;
        if (q == 0) begin
            r = 1;
        end else if (cdb_valid_in && cdb_tag_in == q) begin
            r = 1; v = cdb_value_in;
        end else begin
            foreach (m_q[i]) if (m_q[i].tag == int'(q)) begin r = m_q[i].ready; v = m_q[i].value; end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        en_from_dispatcher = 0; rd_from_dispatcher = 0;
        is_store_from_dispatcher = 0; is_branch_from_dispatcher = 0;
        pred_taken_from_dispatcher = 0; alt_pc_from_dispatcher = 0;
        cdb_valid_in = 0; cdb_tag_in = 0; cdb_value_in = 0; cdb_taken_in = 0;
        Q1_query_from_dispatcher = 0; Q2_query_from_dispatcher = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input bit st, input bit br, input bit pred,
                         input logic [31:0] pc);
        idle();
        en_from_dispatcher = 1; rd_from_dispatcher = rd; is_store_from_dispatcher = st;
        is_branch_from_dispatcher = br; pred_taken_from_dispatcher = pred; alt_pc_from_dispatcher = pc;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input bit taken);
        idle();
        cdb_valid_in = 1; cdb_tag_in = tag; cdb_value_in = val; cdb_taken_in = taken;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1; rst_in = 0;
        tick();
        rst_in = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (commit_flag_to_regfile !== 0 || store_commit_flag_to_lsb !== 0 || rollback_flag !== 0)
            $display("FAIL reset_flags: got %b%b%b want 000", commit_flag_to_regfile, store_commit_flag_to_lsb, rollback_flag);
        else n_pass++;
        n_checks++; if (rd_to_regfile !== 0 || Q_to_regfile !== 0 || V_to_regfile !== 0 || store_tag_to_lsb !== 0 || rollback_pc !== 0)
            $display("FAIL reset_data: rd=%0d Q=%0d V=%h stag=%0d pc=%h want all 0", rd_to_regfile, Q_to_regfile, V_to_regfile, store_tag_to_lsb, rollback_pc);
        else n_pass++;
        n_checks++; if (tag_to_dispatcher !== 5'd1 || full_to_dispatcher !== 1'b0)
            $display("FAIL reset_tag_full: tag=%0d full=%b want 1/0", tag_to_dispatcher, full_to_dispatcher);
        else n_pass++;
        // A ready entry must vanish on a reset without being committed.
        alloc(5'd9, 0, 0, 0, 0); tick();
        cdb(5'd1, 32'h55, 0); tick();
        idle(); rst_in = 0; tick(); rst_in = 1;
        n_checks++; if (commit_flag_to_regfile !== 0 || tag_to_dispatcher !== 5'd1)
            $display("FAIL reset_midstream: commit=%b tag=%0d want 0/1", commit_flag_to_regfile, tag_to_dispatcher);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_basic_commit();
        do_reset();
        alloc(5'd5, 0, 0, 0, 0); tick();
        cdb(5'd1, 32'h1234, 0); tick();
        n_checks++; if (commit_flag_to_regfile !== 0)
            $display("FAIL basic_early: commit=%b want 0 one cycle after CDB", commit_flag_to_regfile);
        else n_pass++;
        idle(); tick();
        n_checks++; if (commit_flag_to_regfile !== 1 || rd_to_regfile !== 5'd5 || Q_to_regfile !== 5'd1 || V_to_regfile !== 32'h1234)
            $display("FAIL basic_commit: flag=%b rd=%0d Q=%0d V=%h want 1/5/1/1234", commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile);
        else n_pass++;
        tick();
        n_checks++; if (commit_flag_to_regfile !== 0)
            $display("FAIL basic_pulse: flag=%b want 0 after one cycle", commit_flag_to_regfile);
        else n_pass++;
        $display("test_basic_commit done");
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) begin alloc(5'(i + 1), 0, 0, 0, 0); tick(); end
        n_checks++; if (full_to_dispatcher !== 1 || tag_to_dispatcher !== 5'd1)
            $display("FAIL full_set: full=%b tag=%0d want 1/1", full_to_dispatcher, tag_to_dispatcher);
        else n_pass++;
        alloc(5'd31, 0, 0, 0, 32'hDEAD); tick();
        n_checks++; if (full_to_dispatcher !== 1 || tag_to_dispatcher !== 5'd1)
            $display("FAIL full_ignore: full=%b tag=%0d want 1/1", full_to_dispatcher, tag_to_dispatcher);
        else n_pass++;
        cdb(5'd1, 32'hCAFE, 0); tick();
        idle(); tick();
        n_checks++; if (commit_flag_to_regfile !== 1 || rd_to_regfile !== 5'd1 || Q_to_regfile !== 5'd1 || V_to_regfile !== 32'hCAFE)
            $display("FAIL full_commit: flag=%b rd=%0d Q=%0d V=%h want 1/1/1/cafe", commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile);
        else n_pass++;
        n_checks++; if (full_to_dispatcher !== 0 || tag_to_dispatcher !== 5'd1)
            $display("FAIL full_free: full=%b tag=%0d want 0/1", full_to_dispatcher, tag_to_dispatcher);
        else n_pass++;
        $display("test_full_wrap done");
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 1; i <= 3; i++) begin alloc(5'(i + 10), 0, 0, 0, 0); tick(); end
        cdb(5'd2, 32'h22, 0); tick();
        cdb(5'd3, 32'h33, 0); tick();
        n_checks++; if (commit_flag_to_regfile !== 0)
            $display("FAIL inorder_wait: commit=%b want 0 before tag 1 ready", commit_flag_to_regfile);
        else n_pass++;
        cdb(5'd1, 32'h11, 0); tick();
        idle();
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (commit_flag_to_regfile !== 1 || Q_to_regfile !== 5'(i) || rd_to_regfile !== 5'(i + 10) || V_to_regfile !== 32'(i * 17))
                $display("FAIL inorder_commit%0d: flag=%b Q=%0d rd=%0d V=%h want 1/%0d/%0d/%h", i, commit_flag_to_regfile, Q_to_regfile, rd_to_regfile, V_to_regfile, i, i + 10, i * 17);
            else n_pass++;
        end
        $display("test_in_order done");
    endtask

    task automatic test_rollback();
        do_reset();
        alloc(5'd0, 0, 1, 0, 32'h100); tick();
        alloc(5'd7, 0, 0, 0, 0); tick();
        cdb(5'd2, 32'h77, 0); tick();
        cdb(5'd1, 32'h0, 1); tick();
        idle(); tick();
        n_checks++; if (rollback_flag !== 1 || rollback_pc !== 32'h100 || commit_flag_to_regfile !== 0)
            $display("FAIL rollback_pulse: rb=%b pc=%h commit=%b want 1/100/0", rollback_flag, rollback_pc, commit_flag_to_regfile);
        else n_pass++;
        n_checks++; if (tag_to_dispatcher !== 5'd1 || full_to_dispatcher !== 0)
            $display("FAIL rollback_empty: tag=%0d full=%b want 1/0", tag_to_dispatcher, full_to_dispatcher);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (commit_flag_to_regfile !== 0 || rollback_flag !== 0)
                $display("FAIL rollback_after%0d: commit=%b rb=%b want 0/0", i, commit_flag_to_regfile, rollback_flag);
            else n_pass++;
        end
        $display("test_rollback done");
    endtask

    task automatic test_query_bypass();
        do_reset();
        for (int i = 1; i <= 3; i++) begin alloc(5'(i), 0, 0, 0, 0); tick(); end
        cdb(5'd3, 32'hAA, 0);
        Q1_query_from_dispatcher = 5'd3; Q2_query_from_dispatcher = 5'd0;
        #1;
        n_checks++; if (ready1_to_dispatcher !== 1 || V1_to_dispatcher !== 32'hAA)
            $display("FAIL query_bypass: ready1=%b V1=%h want 1/aa", ready1_to_dispatcher, V1_to_dispatcher);
        else n_pass++;
        n_checks++; if (ready2_to_dispatcher !== 1 || V2_to_dispatcher !== 32'h0)
            $display("FAIL query_zero: ready2=%b V2=%h want 1/0", ready2_to_dispatcher, V2_to_dispatcher);
        else n_pass++;
        Q2_query_from_dispatcher = 5'd2;
        #1;
        n_checks++; if (ready2_to_dispatcher !== 0)
            $display("FAIL query_pending: ready2=%b want 0", ready2_to_dispatcher);
        else n_pass++;
        tick(); idle(); Q1_query_from_dispatcher = 5'd3;
        #1;
        n_checks++; if (ready1_to_dispatcher !== 1 || V1_to_dispatcher !== 32'hAA)
            $display("FAIL query_stored: ready1=%b V1=%h want 1/aa", ready1_to_dispatcher, V1_to_dispatcher);
        else n_pass++;
        $display("test_query_bypass done");
    endtask

    task automatic test_store_rdy();
        do_reset();
        alloc(5'd4, 1, 0, 0, 0); tick();
        cdb(5'd1, 32'h99, 0); tick();
        idle(); rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (store_commit_flag_to_lsb !== 0)
                $display("FAIL store_frozen%0d: store_flag=%b want 0", i, store_commit_flag_to_lsb);
            else n_pass++;
        end
        rdy_in = 1; tick();
        n_checks++; if (store_commit_flag_to_lsb !== 1 || store_tag_to_lsb !== 5'd1 || commit_flag_to_regfile !== 0)
            $display("FAIL store_commit: flag=%b tag=%0d commit=%b want 1/1/0", store_commit_flag_to_lsb, store_tag_to_lsb, commit_flag_to_regfile);
        else n_pass++;
        $display("test_store_rdy done");
    endtask

    task automatic test_random();
        logic        er1, er2;
        logic [31:0] ev1, ev2;
        int          r;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            en_from_dispatcher = ($urandom % 3) != 0;
            rd_from_dispatcher = 5'($urandom);
            is_store_from_dispatcher = ($urandom % 6) == 0;
            is_branch_from_dispatcher = !is_store_from_dispatcher && (($urandom % 6) == 0);
            pred_taken_from_dispatcher = 1'($urandom);
            alt_pc_from_dispatcher = $urandom;
            r = $urandom % 8;
            if (m_q.size() > 0 && r < 5) begin
                cdb_valid_in = 1; cdb_tag_in = 5'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
            end else if (r == 5) begin
                cdb_valid_in = 1; cdb_tag_in = 5'($urandom % (ROB_SIZE + 1));
            end
            cdb_value_in = $urandom; cdb_taken_in = 1'($urandom);
            rdy_in = ($urandom % 10) != 0;
            Q1_query_from_dispatcher = (m_q.size() > 0) ? 5'(m_q[$urandom_range(0, m_q.size() - 1)].tag) : 5'd0;
            Q2_query_from_dispatcher = (($urandom % 2) == 0 && cdb_valid_in) ? cdb_tag_in : 5'd0;
            #1;
            m_query(Q1_query_from_dispatcher, er1, ev1);
            m_query(Q2_query_from_dispatcher, er2, ev2);
            n_checks++; if (full_to_dispatcher !== (m_q.size() == ROB_SIZE) || tag_to_dispatcher !== 5'(m_next_tag))
                $display("FAIL rand_alloc c%0d: full=%b tag=%0d want %b/%0d", cyc, full_to_dispatcher, tag_to_dispatcher, m_q.size() == ROB_SIZE, m_next_tag);
            else n_pass++;
            n_checks++; if (ready1_to_dispatcher !== er1 || (er1 && V1_to_dispatcher !== ev1) || ready2_to_dispatcher !== er2 || (er2 && V2_to_dispatcher !== ev2))
                $display("FAIL rand_query c%0d: r1=%b V1=%h r2=%b V2=%h want %b/%h %b/%h", cyc, ready1_to_dispatcher, V1_to_dispatcher, ready2_to_dispatcher, V2_to_dispatcher, er1, ev1, er2, ev2);
            else n_pass++;
            tick();
            n_checks++; if (commit_flag_to_regfile !== e_commit || rd_to_regfile !== e_rd || Q_to_regfile !== e_q || V_to_regfile !== e_v)
                $display("FAIL rand_commit c%0d: %b rd=%0d Q=%0d V=%h want %b rd=%0d Q=%0d V=%h", cyc, commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile, e_commit, e_rd, e_q, e_v);
            else n_pass++;
            n_checks++; if (store_commit_flag_to_lsb !== e_store || store_tag_to_lsb !== e_stag || rollback_flag !== e_rb || rollback_pc !== e_rbpc)
                $display("FAIL rand_store_rb c%0d: st=%b tag=%0d rb=%b pc=%h want %b/%0d/%b/%h", cyc, store_commit_flag_to_lsb, store_tag_to_lsb, rollback_flag, rollback_pc, e_store, e_stag, e_rb, e_rbpc);
            else n_pass++;
        end
        $display("test_random done");
    endtask

    initial begin
        idle();
        rst_in = 0; rdy_in = 1;
        m_next_tag = 1;
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_in_order();
        test_rollback();
        test_query_bypass();
        test_store_rdy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
